// File: rtl/bar_frame_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bar_frame_decoder: thermometer-frame decoder and fill/drain lock check |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module bar_frame_decoder #(
   parameter int WIDTH = 16,
   parameter int ERR_W = 8,
   localparam int LW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fc,
   input  logic [WIDTH-1:0] frame,
   output logic             valid,
   output logic [LW-1:0]    level,
   output logic             locked,
   output logic             dir,
   output logic             err_shape,
   output logic             err_step,
   output logic             period_done,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {S_SYNC, S_ACQ, S_FILL, S_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    prev_q, prev_d;
   logic [LW-1:0]    level_q, level_d;
   logic             valid_q, valid_d;
   logic             dir_q, dir_d;
   logic             es_q, es_d;
   logic             et_q, et_d;
   logic             pd_q, pd_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   logic [LW-1:0]    k_w;
   logic             shape_ok_w;
   logic             seen_zero_w;
   logic [LW:0]      k_ext_w, inc_w, dec_w;

   // Count leading ones from the MSB; any one after the first zero is malformed.
   always_comb begin
      k_w         = '0;
      shape_ok_w  = 1'b1;
      seen_zero_w = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (frame[i]) begin
            if (seen_zero_w) shape_ok_w = 1'b0;
            else             k_w = k_w + LW'(1);
         end else begin
            seen_zero_w = 1'b1;
         end
      end
   end

   // One extra bit so prev-1 at 0 and prev+1 at WIDTH never match a legal level.
   assign k_ext_w = {1'b0, k_w};
   assign inc_w   = {1'b0, prev_q} + (LW+1)'(1);
   assign dec_w   = {1'b0, prev_q} - (LW+1)'(1);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      level_d = level_q;
      valid_d = 1'b0;
      dir_d   = dir_q;
      es_d    = 1'b0;
      et_d    = 1'b0;
      pd_d    = 1'b0;
      cnt_d   = cnt_q;
      if (fc) begin
         valid_d = 1'b1;
         if (!shape_ok_w) begin
            es_d    = 1'b1;
            state_d = S_SYNC;
         end else begin
            level_d = k_w;
            prev_d  = k_w;
            case (state_q)
               S_SYNC: begin
                  if (k_w == '0)                state_d = S_FILL;
                  else if (k_w == LW'(WIDTH))   state_d = S_DRAIN;
                  else                          state_d = S_ACQ;
               end
               S_ACQ: begin
                  if (k_ext_w == inc_w)
                     state_d = (k_w == LW'(WIDTH)) ? S_DRAIN : S_FILL;
                  else if (k_ext_w == dec_w)
                     state_d = (k_w == '0) ? S_FILL : S_DRAIN;
               end
               S_FILL: begin
                  if (k_ext_w == inc_w) begin
                     if (k_w == LW'(WIDTH)) state_d = S_DRAIN;
                  end else begin
                     et_d    = 1'b1;
                     state_d = S_ACQ;
                  end
               end
               default: begin
                  if (k_ext_w == dec_w) begin
                     if (k_w == '0) begin
                        state_d = S_FILL;
                        pd_d    = 1'b1;
                     end
                  end else begin
                     et_d    = 1'b1;
                     state_d = S_ACQ;
                  end
               end
            endcase
         end
      end
      if (state_d == S_FILL)       dir_d = 1'b1;
      else if (state_d == S_DRAIN) dir_d = 1'b0;
      if ((es_d || et_d) && (cnt_q != {ERR_W{1'b1}}))
         cnt_d = cnt_q + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_SYNC;
         prev_q  <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
         dir_q   <= 1'b0;
         es_q    <= 1'b0;
         et_q    <= 1'b0;
         pd_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         level_q <= level_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         es_q    <= es_d;
         et_q    <= et_d;
         pd_q    <= pd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid       = valid_q;
   assign level       = level_q;
   assign locked      = (state_q == S_FILL) || (state_q == S_DRAIN);
   assign dir         = dir_q;
   assign err_shape   = es_q;
   assign err_step    = et_q;
   assign period_done = pd_q;
   assign err_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bar_frame_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bar_frame_decoder: scoreboard bench for bar_frame_decoder           |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_bar_frame_decoder;

   typedef struct packed {
      logic [4:0] level;
      logic       locked;
      logic       dir;
      logic       es;
      logic       et;
      logic       pd;
      logic [7:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fc;
   logic [15:0] frame;

   logic        valid, locked, dir, err_shape, err_step, period_done;
   logic [4:0]  level;
   logic [7:0]  err_cnt;

   logic        valid_s, locked_s, dir_s, es_s, et_s, pd_s;
   logic [4:0]  level_s;
   logic [1:0]  err_cnt_s;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   bar_frame_decoder #(.WIDTH(16), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .fc(fc), .frame(frame),
      .valid(valid), .level(level), .locked(locked), .dir(dir),
      .err_shape(err_shape), .err_step(err_step),
      .period_done(period_done), .err_cnt(err_cnt)
   );

   // Narrow-counter instance sharing stimulus, used for saturation checks.
   bar_frame_decoder #(.WIDTH(16), .ERR_W(2)) u_sat (
      .clk(clk), .rst(rst), .fc(fc), .frame(frame),
      .valid(valid_s), .level(level_s), .locked(locked_s), .dir(dir_s),
      .err_shape(es_s), .err_step(et_s),
      .period_done(pd_s), .err_cnt(err_cnt_s)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] th(input int k);
      logic [31:0] t;
      t = 32'hFFFF_0000 >> k;
      return t[15:0];
   endfunction

   function automatic exp_t mk(input int lv, input bit lk, input bit d,
                               input bit es, input bit et, input bit pd,
                               input int c);
      exp_t e;
      e.level  = 5'(lv);
      e.locked = lk;
      e.dir    = d;
      e.es     = es;
      e.et     = et;
      e.pd     = pd;
      e.cnt    = 8'(c);
      return e;
   endfunction

   task automatic send(input logic [15:0] f, input exp_t e);
      fc    = 1'b1;
      frame = f;
      q.push_back(e);
      @(negedge clk);
      fc = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("level",       int'(level),       int'(mon_e.level));
            chk("locked",      int'(locked),      int'(mon_e.locked));
            chk("dir",         int'(dir),         int'(mon_e.dir));
            chk("err_shape",   int'(err_shape),   int'(mon_e.es));
            chk("err_step",    int'(err_step),    int'(mon_e.et));
            chk("period_done", int'(period_done), int'(mon_e.pd));
            chk("err_cnt",     int'(err_cnt),     int'(mon_e.cnt));
            chk("sat_err_cnt", int'(err_cnt_s),
                (mon_e.cnt > 8'd3) ? 3 : int'(mon_e.cnt));
         end
      end else if (err_shape || err_step || period_done) begin
         chk("stray_pulse", 1, 0);
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"},  int'(valid),   0);
      chk({tag, "_level"},  int'(level),   0);
      chk({tag, "_locked"}, int'(locked),  0);
      chk({tag, "_dir"},    int'(dir),     0);
      chk({tag, "_pulses"}, int'({err_shape, err_step, period_done}), 0);
      chk({tag, "_cnt"},    int'(err_cnt), 0);
      chk({tag, "_satcnt"}, int'(err_cnt_s), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b0;
      fc    = 1'b0;
      frame = 16'h0000;
      idle(3);
      chk_reset("por");
      rst = 1'b1;
      idle(1);

      // Full sweep, one frame every 4 cycles.
      for (int i = 0; i <= 16; i++) begin
         send(th(i), mk(i, 1, (i == 16) ? 0 : 1, 0, 0, 0, 0));
         idle(3);
      end
      for (int i = 15; i >= 0; i--) begin
         send(th(i), mk(i, 1, (i == 0) ? 1 : 0, 0, 0, (i == 0), 0));
         idle(3);
      end

      // Shape error while locked in FILL at level 3.
      send(th(1), mk(1, 1, 1, 0, 0, 0, 0));
      send(th(2), mk(2, 1, 1, 0, 0, 0, 0));
      send(th(3), mk(3, 1, 1, 0, 0, 0, 0));
      send(16'hB000, mk(3, 0, 1, 1, 0, 0, 1));
      send(th(5), mk(5, 0, 1, 0, 0, 0, 1));
      send(th(6), mk(6, 1, 1, 0, 0, 0, 1));

      // Step errors in FILL: skip 7->9, then repeat of level 3.
      send(th(7),  mk(7,  1, 1, 0, 0, 0, 1));
      send(th(9),  mk(9,  0, 1, 0, 1, 0, 2));
      send(th(10), mk(10, 1, 1, 0, 0, 0, 2));
      send(th(2),  mk(2,  0, 1, 0, 1, 0, 3));
      send(th(3),  mk(3,  1, 1, 0, 0, 0, 3));
      send(th(3),  mk(3,  0, 1, 0, 1, 0, 4));
      idle(2);

      // Fresh reset, then five malformed frames for counter saturation.
      rst = 1'b0;
      idle(1);
      rst = 1'b1;
      chk_reset("rst2");
      send(16'h0001, mk(0, 0, 0, 1, 0, 0, 1));
      send(16'hB000, mk(0, 0, 0, 1, 0, 0, 2));
      send(16'h5555, mk(0, 0, 0, 1, 0, 0, 3));
      send(16'h8001, mk(0, 0, 0, 1, 0, 0, 4));
      send(16'h0F00, mk(0, 0, 0, 1, 0, 0, 5));
      idle(2);

      // Back-to-back frames, fc high every cycle.
      for (int i = 0; i < 16; i++)
         send(th(i), mk(i, 1, 1, 0, 0, 0, 5));

      // Reset on a cycle with fc=1: frame discarded, outputs at reset values.
      rst   = 1'b0;
      fc    = 1'b1;
      frame = th(8);
      @(negedge clk);
      fc  = 1'b0;
      rst = 1'b1;
      chk_reset("rst_fc");
      send(th(4), mk(4, 0, 0, 0, 0, 0, 0));
      send(th(5), mk(5, 1, 1, 0, 0, 0, 0));

      // fc gating: frame changes with fc low are ignored.
      for (int i = 0; i < 6; i++) begin
         frame = (i[0]) ? 16'hB000 : th(12);
         @(negedge clk);
      end
      chk("gated_level",  int'(level),  5);
      chk("gated_locked", int'(locked), 1);
      send(th(6), mk(6, 1, 1, 0, 0, 0, 0));

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      idle(2);
      chk("queue_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bar_frame_decoder.md
# bar_frame_decoder

Receive-side checker for the LED bar animation. It samples the 16-bit frame bus each time the frame strobe fires and decodes the thermometer pattern into a fill level. It locks onto the fill/drain sweep and flags malformed or out-of-sequence frames. It sits on the LED display path beside the frame generator and drives status and debug outputs; it never drives the LEDs.

## Interface

Parameters:
- WIDTH, 16: frame width in LEDs; fill level ranges 0..WIDTH.
- ERR_W, 8: width of the saturating error counter.
- LW = $clog2(WIDTH+1) (localparam, 5 at default): level width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on clk.
- fc  in  1  frame strobe, one cycle per new frame; may be high on consecutive cycles.
- frame  in  WIDTH  LED frame; sampled only when fc=1.
- valid  out  1  one-cycle pulse, cycle after every sampled frame.
- level  out  LW  decoded fill level (number of leading ones from bit WIDTH-1).
- locked  out  1  1 while in FILL or DRAIN.
- dir  out  1  1 = filling, 0 = draining; meaningful only when locked=1.
- err_shape  out  1  pulse with valid when the frame is not a thermometer code.
- err_step  out  1  pulse with valid when a locked sequence breaks.
- period_done  out  1  pulse with valid when a drain reaches level 0.
- err_cnt  out  ERR_W  saturating count of err_shape plus err_step events.

## Operation

- Well-formed frame: k ones in bits WIDTH-1..WIDTH-k, zeros below, 0 ≤ k ≤ WIDTH. Any other pattern is malformed.
- Internal prev register (LW bits) holds the last accepted level.
- SYNC (reset state):
  - Well-formed frame: prev=level=k.
  - k==0 → FILL.
  - k==WIDTH → DRAIN.
  - Otherwise → ACQ.
  - Malformed: err_shape, stay in SYNC.
- ACQ:
  - Well-formed k==prev+1 → FILL, except k==WIDTH → DRAIN.
  - Well-formed k==prev-1 → DRAIN, except k==0 → FILL.
  - Any other well-formed k: stay in ACQ, prev=k, no error.
  - Malformed: err_shape, → SYNC.
- FILL (dir=1):
  - Expect k==prev+1.
  - Match: prev=k; k==WIDTH → DRAIN.
  - Well-formed mismatch (including repeat of same level): err_step, prev=k, → ACQ.
  - Malformed: err_shape, → SYNC.
- DRAIN (dir=0):
  - Expect k==prev-1.
  - Match: prev=k; k==0 → FILL and period_done.
  - Mismatch: err_step, prev=k, → ACQ.
  - Malformed: err_shape, → SYNC.
- level output:
  - Updates to k on every well-formed frame.
  - Holds its previous value on a malformed frame.
- dir output:
  - 1 when the state after the transition is FILL, 0 when DRAIN.
  - Holds its last value otherwise.
- err_cnt:
  - +1 per err_shape or err_step; both can never fire on the same frame.
  - Saturates at 2^ERR_W-1; never wraps.
- Arithmetic:
  - prev±1 is computed in LW+1 bits, so 0-1 and WIDTH+1 never alias to a legal level.

## Timing

- Latency: frame sampled on a cycle with fc=1.
  - All outputs and the state update on the next rising edge, i.e. visible one cycle later.
  - valid, err_shape, err_step and period_done are high for exactly that one cycle.
- Back-to-back fc (every cycle): one full decode per cycle, no stalls, no dropped frames.
- fc=0: frame is ignored, state and registered outputs hold, all pulses are 0.
- Reset values (rst=0 at an edge): valid=0, level=0, locked=0, dir=0, all error and period pulses 0, err_cnt=0, prev=0, state=SYNC.
- Reset priority: reset overrides a simultaneous fc; that frame is discarded.
- Reset mid-sweep: behaviour is identical to power-on.

## Test plan

- Full sweep, fc every 4 cycles:
  - Stimulus: reset, then levels 0,1,…,16,15,…,0.
  - Response: locked=1 from the first valid; dir=1 through level 16, then 0.
  - period_done pulses once, on the final 0.
  - err_cnt=0; 33 valid pulses.
- Shape error while locked:
  - Stimulus: frame 16'hB000 (1011_0000…) while locked.
  - Response: err_shape=1, locked=0, level held, err_cnt=1.
  - Then send levels 5, 6 → ACQ then FILL; locked=1 and dir=1 after level 6.
- Step error in FILL:
  - Stimulus: at level 7, send level 9, then 10.
  - Response: err_step=1, level=9, locked=0; after 10, locked=1 and dir=1.
  - Repeat at level 3 by resending 3: err_step=1.
- Saturation:
  - Stimulus: ERR_W=2, five malformed frames.
  - Response: err_cnt = 1, 2, 3, 3, 3.
- Back-to-back and reset interplay:
  - Stimulus: fc high for 16 consecutive cycles with levels 0..15.
  - Response: 16 consecutive valid pulses with correct levels.
  - Stimulus: assert rst=0 on a cycle with fc=1.
  - Response: next cycle all outputs at reset values, and the following level 4 frame enters ACQ.
- fc gating:
  - Stimulus: change frame on cycles with fc=0.
  - Response: no valid pulse, level unchanged.
